// File: rtl/line_window_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : line_window_buffer_if                                         |
// | Brief    : Pixel-in / tap-column-out bus for line_window_buffer.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface line_window_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_NUM   = 3,
    parameter int COL_WIDTH  = 12
);
    logic                           sof;
    logic                           in_valid;
    logic [DATA_WIDTH-1:0]          in_data;
    logic                           out_valid;
    logic [LINE_NUM*DATA_WIDTH-1:0] out_data;
    logic [COL_WIDTH-1:0]           out_col;
    logic                           out_eol;

    modport master (
        output sof, in_valid, in_data,
        input  out_valid, out_data, out_col, out_eol
    );

    modport slave (
        input  sof, in_valid, in_data,
        output out_valid, out_data, out_col, out_eol
    );
endinterface
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : line_window_buffer                                            |
// | Brief    : Raster line buffer emitting a LINE_NUM-tap vertical column.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module line_window_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int COL_WIDTH   = 12,
    parameter int LINE_NUM    = 3,
    parameter int BORDER_MODE = 0
) (
    input  wire logic           clk,
    input  wire logic           rst,
    line_window_buffer_if.slave bus
);
    localparam int c_NSTORE  = LINE_NUM - 1;
    localparam int c_ADDR_W  = $clog2(IMG_WIDTH);
    localparam int c_WSEL_W  = (c_NSTORE > 1) ? $clog2(c_NSTORE) : 1;
    localparam int c_LINES_W = $clog2(c_NSTORE + 1);

    localparam logic [COL_WIDTH-1:0] c_LAST_COL  = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [c_WSEL_W-1:0]  c_LAST_WSEL = c_WSEL_W'(c_NSTORE - 1);
    localparam logic [c_LINES_W-1:0] c_FULL      = c_LINES_W'(c_NSTORE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [COL_WIDTH-1:0]  r_col;
    logic [COL_WIDTH-1:0]  w_col_nx;
    logic [c_LINES_W-1:0]  r_lines;
    logic [c_LINES_W-1:0]  w_lines_nx;
    logic [c_WSEL_W-1:0]   r_wsel;
    logic [c_WSEL_W-1:0]   w_wsel_nx;

    // sof clears the counters before the same-cycle pixel is processed
    state_t                w_state;
    logic [COL_WIDTH-1:0]  w_col;
    logic [c_LINES_W-1:0]  w_lines;
    logic [c_WSEL_W-1:0]   w_wsel;

    assign w_state = bus.sof ? IDLE : r_state;
    assign w_col   = bus.sof ? '0   : r_col;
    assign w_lines = bus.sof ? '0   : r_lines;
    assign w_wsel  = bus.sof ? '0   : r_wsel;

    logic                  w_wrap;
    logic                  w_emit;
    logic [c_ADDR_W-1:0]   w_addr;
    logic [DATA_WIDTH-1:0] w_rd [c_NSTORE];
    logic [LINE_NUM*DATA_WIDTH-1:0] w_taps;

    assign w_addr = w_col[c_ADDR_W-1:0];
    assign w_emit = bus.in_valid && ((BORDER_MODE != 0) || (w_state == RUN));

    always_comb begin
        w_wrap     = 1'b0;
        w_col_nx   = w_col;
        w_lines_nx = w_lines;
        w_wsel_nx  = w_wsel;
        w_state_nx = w_state;
        if (bus.in_valid) begin
            w_wrap = (w_col == c_LAST_COL);
            if (w_wrap) begin
                w_col_nx  = '0;
                w_wsel_nx = (w_wsel == c_LAST_WSEL) ? '0 : w_wsel + c_WSEL_W'(1);
                if (w_lines != c_FULL)
                    w_lines_nx = w_lines + c_LINES_W'(1);
            end else begin
                w_col_nx = w_col + COL_WIDTH'(1);
            end
            case (w_state)
                IDLE, FILL: w_state_nx = (w_lines_nx == c_FULL) ? RUN : FILL;
                RUN:        w_state_nx = RUN;
                default:    w_state_nx = IDLE;
            endcase
        end
    end

    // Read-first line stores: the combinational read sees the pre-write content
    generate
        for (genvar i = 0; i < c_NSTORE; i++) begin : g_ram
            logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

            always_ff @(posedge clk) begin
                if (bus.in_valid && (w_wsel == c_WSEL_W'(i)))
                    mem[w_addr] <= bus.in_data;
            end

            assign w_rd[i] = mem[w_addr];
        end
    endgenerate

    // Tap k reads the store written k lines ago: store j where wsel == (j+k) mod N
    always_comb begin
        w_taps = '0;
        w_taps[DATA_WIDTH-1:0] = bus.in_data;
        for (int k = 1; k < LINE_NUM; k++) begin
            for (int j = 0; j < c_NSTORE; j++) begin
                if ((int'(w_wsel) == ((j + k) % c_NSTORE)) &&
                    ((BORDER_MODE == 0) || (k <= int'(w_lines))))
                    w_taps[k*DATA_WIDTH +: DATA_WIDTH] = w_rd[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col         <= '0;
            r_lines       <= '0;
            r_wsel        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_col   <= '0;
            bus.out_eol   <= 1'b0;
        end else begin
            r_col         <= w_col_nx;
            r_lines       <= w_lines_nx;
            r_wsel        <= w_wsel_nx;
            bus.out_valid <= w_emit;
            if (w_emit) begin
                bus.out_data <= w_taps;
                bus.out_col  <= w_col;
                bus.out_eol  <= w_wrap;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_line_window_buffer                                         |
// | Brief    : Directed bench: border modes, gaps, sof, rst, 5-tap config.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_line_window_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [23:0] last0 = '0;
    logic [23:0] last1 = '0;

    always #5 clk = ~clk;

    line_window_buffer_if #(.DATA_WIDTH(8), .LINE_NUM(3), .COL_WIDTH(12)) b0 ();
    line_window_buffer_if #(.DATA_WIDTH(8), .LINE_NUM(3), .COL_WIDTH(12)) b1 ();
    line_window_buffer_if #(.DATA_WIDTH(8), .LINE_NUM(5), .COL_WIDTH(12)) b2 ();

    line_window_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .COL_WIDTH(12),
                         .LINE_NUM(3), .BORDER_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    line_window_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(4), .COL_WIDTH(12),
                         .LINE_NUM(3), .BORDER_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    line_window_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(2), .COL_WIDTH(12),
                         .LINE_NUM(5), .BORDER_MODE(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected 3-tap column for frame line l, column c; missing lines read as 0
    function automatic logic [23:0] exp3(input int base, input int l, input int c);
        logic [23:0] e;
        e = '0;
        e[7:0] = 8'(base + l*16 + c);
        if (l >= 1) e[15:8]  = 8'(base + (l-1)*16 + c);
        if (l >= 2) e[23:16] = 8'(base + (l-2)*16 + c);
        return e;
    endfunction

    task automatic pix3(input bit s, input int l, input int c, input int base);
        logic [23:0] e;
        b0.sof = s; b0.in_valid = 1'b1; b0.in_data = 8'(base + l*16 + c);
        b1.sof = s; b1.in_valid = 1'b1; b1.in_data = 8'(base + l*16 + c);
        @(posedge clk); #1;
        b0.sof = 1'b0; b0.in_valid = 1'b0;
        b1.sof = 1'b0; b1.in_valid = 1'b0;
        e = exp3(base, l, c);
        chk($sformatf("u0 valid l%0d c%0d", l, c), 64'(b0.out_valid), 64'(l >= 2));
        if (l >= 2) begin
            last0 = e;
            chk($sformatf("u0 col l%0d c%0d", l, c), 64'(b0.out_col), 64'(c));
            chk($sformatf("u0 eol l%0d c%0d", l, c), 64'(b0.out_eol), 64'(c == 3));
        end
        chk($sformatf("u0 data l%0d c%0d", l, c), 64'(b0.out_data), 64'(last0));
        last1 = e;
        chk($sformatf("u1 valid l%0d c%0d", l, c), 64'(b1.out_valid), 64'd1);
        chk($sformatf("u1 data l%0d c%0d", l, c), 64'(b1.out_data), 64'(e));
        chk($sformatf("u1 col l%0d c%0d", l, c), 64'(b1.out_col), 64'(c));
    endtask

    task automatic idle3();
        @(posedge clk); #1;
        chk("u0 gap valid", 64'(b0.out_valid), 64'd0);
        chk("u1 gap valid", 64'(b1.out_valid), 64'd0);
        chk("u0 gap hold", 64'(b0.out_data), 64'(last0));
        chk("u1 gap hold", 64'(b1.out_data), 64'(last1));
    endtask

    task automatic pix5(input int l, input int c);
        logic [39:0] e;
        b2.in_valid = 1'b1; b2.in_data = 8'(l*16 + c);
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
        chk($sformatf("u2 valid l%0d c%0d", l, c), 64'(b2.out_valid), 64'(l >= 4));
        if (l >= 4) begin
            e = '0;
            for (int k = 0; k < 5; k++) e[k*8 +: 8] = 8'((l-k)*16 + c);
            chk($sformatf("u2 data l%0d c%0d", l, c), 64'(b2.out_data), 64'(e));
            chk($sformatf("u2 eol l%0d c%0d", l, c), 64'(b2.out_eol), 64'(c == 1));
        end
    endtask

    initial begin
        b0.sof = 1'b0; b0.in_valid = 1'b0; b0.in_data = '0;
        b1.sof = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0;
        b2.sof = 1'b0; b2.in_valid = 1'b0; b2.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst u0 valid", 64'(b0.out_valid), 64'd0);
        chk("rst u0 data", 64'(b0.out_data), 64'd0);
        chk("rst u0 col", 64'(b0.out_col), 64'd0);
        chk("rst u0 eol", 64'(b0.out_eol), 64'd0);
        chk("rst u1 valid", 64'(b1.out_valid), 64'd0);
        chk("rst u2 valid", 64'(b2.out_valid), 64'd0);
        rst = 1'b0;

        // Continuous 4-line frame
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 4; c++) begin
                pix3(1'b0, l, c, 0);
                if (l == 0 && c == 2) chk("u1 l0c2 taps", 64'(b1.out_data), 64'h00_00_02);
                if (l == 1 && c == 2) chk("u1 l1c2 taps", 64'(b1.out_data), 64'h00_02_12);
                if (l == 2 && c == 1) chk("u0 l2c1 taps", 64'(b0.out_data), 64'h01_11_21);
                if (l == 3 && c == 3) chk("u0 l3c3 taps", 64'(b0.out_data), 64'h13_23_33);
            end
        idle3();

        // in_valid toggling 1010 across every line wrap, new frame via sof
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 4; c++) begin
                pix3(l == 0 && c == 0, l, c, 0);
                idle3();
            end

        // sof together with a pixel at line 2 col 2
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 4; c++) pix3(l == 0 && c == 0, l, c, 0);
        pix3(1'b0, 2, 0, 0);
        pix3(1'b0, 2, 1, 0);
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 4; c++) pix3(l == 0 && c == 0, l, c, 8'h80);
        chk("sof resume taps", 64'(b0.out_data), 64'h83_93_a3);

        // Async reset mid-line 3, then refill
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 4; c++) pix3(l == 0 && c == 0, l, c, 0);
        pix3(1'b0, 3, 0, 0);
        pix3(1'b0, 3, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst u0 valid", 64'(b0.out_valid), 64'd0);
        chk("arst u0 data", 64'(b0.out_data), 64'd0);
        chk("arst u0 col", 64'(b0.out_col), 64'd0);
        chk("arst u1 data", 64'(b1.out_data), 64'd0);
        #1 rst = 1'b0;
        last0 = '0;
        last1 = '0;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 4; c++) pix3(1'b0, l, c, 8'h40);

        // 5 taps, 2-pixel lines: store select wraps after four lines
        for (int l = 0; l < 6; l++)
            for (int c = 0; c < 2; c++) begin
                pix5(l, c);
                if (l == 5 && c == 0) chk("u2 l5c0 taps", 64'(b2.out_data), 64'h10_20_30_40_50);
            end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised line buffer for the 3x3 matrix path. It accepts a raster pixel stream and emits, per input pixel, a vertical column of LINE_NUM taps. The taps are the current pixel plus the same column from the previous LINE_NUM-1 lines. It sits between the pixel source and the window/convolution stage and replaces the fixed single-FIFO line buffer. Line length, tap count, data width and start-up border mode are all parameters.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line (2..4096).
- COL_WIDTH, 12, column counter width; must satisfy 2**COL_WIDTH >= IMG_WIDTH.
- LINE_NUM, 3, taps per output column (2..5); LINE_NUM-1 line stores.
- BORDER_MODE, 0, start-up behaviour:
  - 0: suppress output until LINE_NUM-1 full lines are stored.
  - 1: emit from the first line, with unfilled taps forced to 0.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- sof  in  1  start-of-frame pulse; restarts column/line counting and the fill state.
- in_valid  in  1  in_data is a pixel this cycle.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  out_data is a valid column.
- out_data  out  LINE_NUM*DATA_WIDTH  tap k (k lines above the current line) at bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 is the current pixel.
- out_col  out  COL_WIDTH  column of the emitted pixel.
- out_eol  out  1  emitted pixel is column IMG_WIDTH-1.

## Operation
- Storage: LINE_NUM-1 single-port-per-cycle RAMs, each IMG_WIDTH x DATA_WIDTH, inferred, no reset.
- A write-select pointer `wsel` (0..LINE_NUM-2) names the RAM holding the oldest stored line.
- Each accepted pixel at column `col`:
  - All RAMs are read at `col`, read-first: the old content is returned even from the RAM being written.
  - in_data is written to RAM[wsel] at `col`.
- Tap mapping: tap k (1..LINE_NUM-1) = read data of RAM[(wsel + LINE_NUM-1 - k) mod (LINE_NUM-1)], using the `wsel` captured with the pixel.
- Column counter: increments per accepted pixel; at IMG_WIDTH-1 it wraps to 0. On that wrap:
  - `wsel` advances mod LINE_NUM-1;
  - `lines` (stored full lines) increments, saturating at LINE_NUM-1.
- State machine:
  - IDLE: after reset or sof, col=0, lines=0, wsel=0. The first accepted pixel moves to FILL.
  - FILL: lines < LINE_NUM-1. Moves to RUN when the wrap makes lines = LINE_NUM-1.
  - RUN: all taps valid. Leaves only on sof (to IDLE) or rst.
- Output qualification:
  - BORDER_MODE 0: out_valid only for pixels accepted in RUN.
  - BORDER_MODE 1: out_valid for every accepted pixel; tap k is forced to 0 when k > lines at acceptance time.
- sof together with in_valid: counters and state clear first, and that pixel is column 0, line 0 of the new frame (state FILL after the cycle).
- sof does not clear RAM contents; stale data is never emitted because of the qualification/zeroing rules above.
- Mid-line sof: the partial line is discarded and counting restarts.
- No backpressure: a pixel presented with in_valid is always accepted. in_valid gaps are allowed anywhere, including mid-line.

## Timing
- Latency: exactly 1 cycle from in_valid to out_valid. out_data, out_col and out_eol are registered and aligned with out_valid.
- Throughput: one pixel per cycle sustained, including across the line wrap.
- When out_valid=0, out_data, out_col and out_eol hold their previous values.
- Reset values: out_valid=0, out_data=0, out_col=0, out_eol=0; state IDLE, col=0, lines=0, wsel=0.
- rst asserted mid-operation clears everything on the same edge, asynchronously; the first cycle after deassertion behaves as IDLE.

## Test plan
All scenarios use IMG_WIDTH=4, LINE_NUM=3, DATA_WIDTH=8, with pixels = line*16+col.
- BORDER_MODE 0, continuous stream of 4 lines:
  - no out_valid during lines 0–1;
  - line 2 col 1 -> out_data taps (0x21, 0x11, 0x01), out_col=1;
  - line 3 col 3 -> taps (0x33, 0x23, 0x13) with out_eol=1.
- BORDER_MODE 1, first two lines:
  - line 0 col 2 -> taps (0x02, 0, 0);
  - line 1 col 2 -> taps (0x12, 0x02, 0).
- in_valid toggling 1010… across a line wrap -> same tap values as the continuous case, each out_valid exactly one cycle after its in_valid.
- sof asserted with in_valid at line 2 col 2 (BORDER_MODE 0):
  - that pixel is frame line 0 col 0;
  - out_valid stays low for the next 8 accepted pixels, then resumes with new-frame data only.
- rst pulse mid-line 3 -> all outputs 0 immediately. After release, 2 lines of refill elapse before out_valid (BORDER_MODE 0).
- LINE_NUM=5 with IMG_WIDTH=2 for 6 lines -> line 5 col 0 gives taps (0x50, 0x40, 0x30, 0x20, 0x10); `wsel` wraps correctly.
